// File: rtl/psum_ofifo_pkg.sv
// Shared sizing constants for the systolic array south-edge output FIFO.
// Also used by the array top so both sides agree on psum width and column count.
package psum_ofifo_pkg;

   localparam int PSUM_BW     = 16;
   localparam int COL         = 8;
   localparam int OFIFO_DEPTH = 64;

   // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
   function automatic int ptr_width(input int d);
      return (d <= 2) ? 1 : $clog2(d);
   endfunction

endpackage

// File: rtl/ofifo_col.sv
// Single-column first-word-fall-through FIFO for one column of partial sums.
// A write into a full FIFO is dropped and flagged, even if the same edge pops.
// The head entry is presented combinationally; an empty FIFO drives zero.
module ofifo_col
   import psum_ofifo_pkg::*;
#(
   parameter int psum_bw = PSUM_BW,
   parameter int depth   = OFIFO_DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr,
   input  logic [psum_bw-1:0] in,
   input  logic               pop,
   output logic [psum_bw-1:0] out,
   output logic               empty,
   output logic               full,
   output logic               drop
);

   localparam int aw = ptr_width(depth);
   localparam logic [aw:0]   depth_cnt = (aw+1)'(depth);
   localparam logic [aw:0]   cnt_one   = (aw+1)'(1);
   localparam logic [aw-1:0] ptr_one   = aw'(1);

   logic [psum_bw-1:0] mem [depth];

   logic [aw-1:0] wptr_reg, wptr_next;
   logic [aw-1:0] rptr_reg, rptr_next;
   logic [aw:0]   count_reg, count_next;
   logic          accept;
   logic          take;

   assign empty  = (count_reg == '0);
   assign full   = (count_reg == depth_cnt);
   assign accept = wr & ~full;
   assign drop   = wr & full;
   // The top only pops when every column holds data; the guard keeps this
   // column self-consistent if it is ever reused standalone.
   assign take   = pop & ~empty;

   // Next pointers and occupancy; a simultaneous accept and pop leaves count alone.
   always_comb begin
      wptr_next  = wptr_reg;
      rptr_next  = rptr_reg;
      count_next = count_reg;
      if (accept) begin
         wptr_next = wptr_reg + ptr_one;
      end
      if (take) begin
         rptr_next = rptr_reg + ptr_one;
      end
      case ({accept, take})
         2'b10:   count_next = count_reg + cnt_one;
         2'b01:   count_next = count_reg - cnt_one;
         default: count_next = count_reg;
      endcase
   end

   // Pointer and count state; reset discards all buffered entries.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
      end else begin
         wptr_reg  <= wptr_next;
         rptr_reg  <= rptr_next;
         count_reg <= count_next;
      end
   end

   // Storage write; contents are not reset since empty hides stale data.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wptr_reg] <= in;
      end
   end

   assign out = empty ? '0 : mem[rptr_reg];

endmodule

// File: rtl/psum_ofifo.sv
// South-edge receive buffer of the systolic array. Each column is captured
// independently under its own valid bit (columns arrive skewed), and the
// heads of all columns are presented together as one aligned psum vector.
module psum_ofifo
   import psum_ofifo_pkg::*;
#(
   parameter int col     = COL,
   parameter int psum_bw = PSUM_BW,
   parameter int depth   = OFIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [psum_bw*col-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [psum_bw*col-1:0] out,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   o_ovf,
   output logic                   o_unf
);

   logic [col-1:0] empty_v;
   logic [col-1:0] full_v;
   logic [col-1:0] drop_v;
   logic           pop;
   logic           ovf_reg;
   logic           unf_reg;

   // A vector exists only when every column has its k-th entry.
   assign o_valid = ~|empty_v;
   assign o_full  = |full_v;
   assign o_ready = ~o_full;
   // One pop advances all columns together so vectors never misalign.
   assign pop     = rd & o_valid;

   genvar gi;
   generate
      for (gi = 0; gi < col; gi++) begin : g_col
         ofifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth)
         ) u_col (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[gi]),
            .in    (in[psum_bw*gi +: psum_bw]),
            .pop   (pop),
            .out   (out[psum_bw*gi +: psum_bw]),
            .empty (empty_v[gi]),
            .full  (full_v[gi]),
            .drop  (drop_v[gi])
         );
      end
   endgenerate

   // Sticky error flags: dropped write on a full column, read with no vector.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_reg <= 1'b0;
         unf_reg <= 1'b0;
      end else begin
         ovf_reg <= ovf_reg | (|drop_v);
         unf_reg <= unf_reg | (rd & ~o_valid);
      end
   end

   assign o_ovf = ovf_reg;
   assign o_unf = unf_reg;

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo: per-column queue model, directed
// scenarios (reset, skew, overflow, streaming, underflow) and a random run.
module tb_psum_ofifo;
   import psum_ofifo_pkg::*;

   localparam int W = PSUM_BW * COL;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [W-1:0]   din = '0;
   logic [COL-1:0] wr_v = '0;
   logic           rd_v = 1'b0;
   logic [W-1:0]   dout;
   logic           o_valid, o_full, o_ready, o_ovf, o_unf;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one queue per column plus the two sticky flags.
   logic [PSUM_BW-1:0] mq [COL][$];
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;

   psum_ofifo dut (
      .clk     (clk),
      .reset   (rst_n),
      .in      (din),
      .wr      (wr_v),
      .rd      (rd_v),
      .out     (dout),
      .o_valid (o_valid),
      .o_full  (o_full),
      .o_ready (o_ready),
      .o_ovf   (o_ovf),
      .o_unf   (o_unf)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit model_valid();
      bit v = 1'b1;
      for (int i = 0; i < COL; i++) if (mq[i].size() == 0) v = 1'b0;
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < COL; i++) mq[i].delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // Compare every observable output with the model's current state.
   task automatic check_state(input string tag);
      logic [W-1:0] e_out;
      bit e_valid;
      bit e_full;
      e_out   = '0;
      e_valid = model_valid();
      e_full  = 1'b0;
      for (int i = 0; i < COL; i++) begin
         if (mq[i].size() > 0) e_out[i*PSUM_BW +: PSUM_BW] = mq[i][0];
         if (mq[i].size() == OFIFO_DEPTH) e_full = 1'b1;
      end
      check_eq({tag, ".out"},   dout,          e_out);
      check_eq({tag, ".valid"}, W'(o_valid),   W'(e_valid));
      check_eq({tag, ".full"},  W'(o_full),    W'(e_full));
      check_eq({tag, ".ready"}, W'(o_ready),   W'(!e_full));
      check_eq({tag, ".ovf"},   W'(o_ovf),     W'(m_ovf));
      check_eq({tag, ".unf"},   W'(o_unf),     W'(m_unf));
   endtask

   // One clock edge of the model: full is judged before the same-edge pop.
   task automatic model_edge(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
      bit v;
      v = model_valid();
      if (r && !v) m_unf = 1'b1;
      for (int i = 0; i < COL; i++) begin
         bit acc;
         acc = w[i] && (mq[i].size() < OFIFO_DEPTH);
         if (w[i] && !acc) m_ovf = 1'b1;
         if (r && v) void'(mq[i].pop_front());
         if (acc) mq[i].push_back(d[i*PSUM_BW +: PSUM_BW]);
      end
   endtask

   // Called at a falling edge: drive, check current state, advance one cycle.
   task automatic cycle(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r, input string tag);
      wr_v = w;
      din  = d;
      rd_v = r;
      check_state(tag);
      @(posedge clk);
      model_edge(w, d, r);
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Assert reset between clock edges and check the flags react at once.
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check_state(tag);
      wr_v = '0;
      rd_v = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] v;
      logic [W-1:0] e;
      int wcnt [COL];

      // ---- power-on reset ----
      repeat (2) @(negedge clk);
      check_state("por");
      rst_n = 1'b1;
      @(negedge clk);

      // ---- skewed fill: column i written at cycle 10+i ----
      repeat (10) cycle('0, rand_vec(), 1'b0, "skew_idle");
      for (int i = 0; i < COL; i++) begin
         v = rand_vec();
         v[i*PSUM_BW +: PSUM_BW] = 16'h1000 + 16'(i);
         cycle(COL'(1) << i, v, 1'b0, "skew_fill");
      end
      e = '0;
      for (int i = 0; i < COL; i++) e[i*PSUM_BW +: PSUM_BW] = 16'h1000 + 16'(i);
      check_eq("skew.vector", dout, e);
      check_eq("skew.valid", W'(o_valid), W'(1'b1));
      cycle('0, rand_vec(), 1'b1, "skew_pop");
      check_eq("skew.valid_after_rd", W'(o_valid), W'(1'b0));

      // ---- reset mid-stream with 5 entries per column ----
      repeat (5) cycle('1, rand_vec(), 1'b0, "mid_fill");
      async_reset("mid_rst");
      @(negedge clk);
      cycle('1, {COL{16'h0001}}, 1'b0, "post_rst_wr");
      check_eq("post_rst.out", dout, {COL{16'h0001}});

      // ---- full / overflow on column 3 ----
      async_reset("ovf_rst");
      @(negedge clk);
      for (int k = 0; k < OFIFO_DEPTH; k++) begin
         v = rand_vec();
         v[3*PSUM_BW +: PSUM_BW] = 16'(k);
         cycle(8'h08, v, 1'b0, "ovf_fill3");
      end
      v = rand_vec();
      v[3*PSUM_BW +: PSUM_BW] = 16'hBEEF;
      cycle(8'h08, v, 1'b0, "ovf_drop");
      check_eq("ovf.full", W'(o_full), W'(1'b1));
      check_eq("ovf.ready", W'(o_ready), W'(1'b0));
      check_eq("ovf.sticky", W'(o_ovf), W'(1'b1));
      for (int k = 0; k < OFIFO_DEPTH; k++) cycle(8'hF7, rand_vec(), 1'b0, "ovf_fill_rest");
      for (int k = 0; k < OFIFO_DEPTH; k++) begin
         check_eq("ovf.col3_data", W'(dout[3*PSUM_BW +: PSUM_BW]), W'(16'(k)));
         cycle('0, rand_vec(), 1'b1, "ovf_drain");
      end
      check_eq("ovf.drained_valid", W'(o_valid), W'(1'b0));

      // ---- steady streaming: write and pop every cycle at depth 4 ----
      async_reset("stream_rst");
      @(negedge clk);
      repeat (4) cycle('1, rand_vec(), 1'b0, "stream_prime");
      repeat (100) cycle('1, rand_vec(), 1'b1, "stream");
      repeat (4) cycle('0, rand_vec(), 1'b1, "stream_drain");
      check_eq("stream.empty", W'(o_valid), W'(1'b0));

      // ---- underflow: column 7 empty ----
      async_reset("unf_rst");
      @(negedge clk);
      repeat (2) cycle(8'h7F, rand_vec(), 1'b0, "unf_fill");
      cycle('0, rand_vec(), 1'b1, "unf_rd");
      check_eq("unf.sticky", W'(o_unf), W'(1'b1));
      cycle('0, rand_vec(), 1'b0, "unf_hold");
      check_eq("unf.still_set", W'(o_unf), W'(1'b1));

      // ---- random traffic: 1000 writes per column, rd gated by validity ----
      async_reset("rand_rst");
      @(negedge clk);
      for (int i = 0; i < COL; i++) wcnt[i] = 0;
      for (int c = 0; c < 20000; c++) begin
         logic [COL-1:0] w;
         logic [COL-1:0] mask;
         bit r;
         bit busy;
         busy = 1'b0;
         mask = '0;
         for (int i = 0; i < COL; i++) begin
            mask[i] = (wcnt[i] < 1000);
            if (mask[i]) busy = 1'b1;
         end
         if (!busy) break;
         w = COL'($urandom) & mask;
         for (int i = 0; i < COL; i++) if (w[i]) wcnt[i]++;
         r = ($urandom_range(0, 99) < 60) && model_valid();
         cycle(w, rand_vec(), r, "rand");
      end
      for (int c = 0; c < 200; c++) begin
         if (!model_valid()) break;
         cycle('0, rand_vec(), 1'b1, "rand_drain");
      end
      check_state("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
